// File: rtl/iir_stim_seq_if.sv
// Handshake and data bundle between the stimulus sequencer and the
// ap_ctrl_hs IIR filter core. The sequencer is the master side.
interface iir_stim_seq_if #(
  parameter int W = 20
);
  logic         core_start;
  logic         core_ready;
  logic         core_done;
  logic [W-1:0] core_return;
  logic [W-1:0] core_x;

  modport master (
    output core_start,
    output core_x,
    input  core_ready,
    input  core_done,
    input  core_return
  );

  modport slave (
    input  core_start,
    input  core_x,
    output core_ready,
    output core_done,
    output core_return
  );
endinterface

// File: rtl/iir_stim_seq.sv
// Stimulus sequencer and response capture for an ap_ctrl_hs IIR core.
// Generates impulse/step/square/ramp samples paced by ap_start/ap_ready,
// and after an arm request records CAP_DEPTH ap_return samples into a
// readable buffer, starting at the first event after arming.
module iir_stim_seq #(
  parameter int W         = 20,
  parameter int PERIOD_W  = 10,
  parameter int CAP_DEPTH = 64,
  parameter int AW        = $clog2(CAP_DEPTH)
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic                enable,
  input  logic [1:0]          mode,
  input  logic [W-1:0]        amplitude,
  input  logic [PERIOD_W-1:0] period,
  iir_stim_seq_if.master      core,
  output logic                stim_event,
  input  logic                cap_arm,
  output logic                cap_busy,
  output logic                cap_full,
  input  logic [AW-1:0]       cap_raddr,
  output logic [W-1:0]        cap_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } cap_state_e;

  localparam logic [1:0] M_IMPULSE = 2'd0;
  localparam logic [1:0] M_STEP    = 2'd1;
  localparam logic [1:0] M_SQUARE  = 2'd2;

  logic                start_d, start_q;
  logic [PERIOD_W-1:0] cnt_d, cnt_q;
  logic                lvl_d, lvl_q;
  logic                step_d, step_q;
  logic [W-1:0]        x_d, x_q;
  logic                evt_d, evt_q;
  cap_state_e          state_d, state_q;
  logic [AW-1:0]       wptr_d, wptr_q;
  logic                buf_we;
  logic [W-1:0]        rdata_q;
  logic [W-1:0]        mem [CAP_DEPTH];

  logic accept;
  logic is_event;

  assign accept   = start_q && core.core_ready;
  assign is_event = accept && (cnt_q == '0);

  // Sample counter, level latches and next stimulus sample; all hold
  // unless the core accepts a sample.
  always_comb begin
    start_d = enable;
    cnt_d   = cnt_q;
    lvl_d   = lvl_q;
    step_d  = step_q;
    x_d     = x_q;
    evt_d   = 1'b0;
    if (accept) begin
      evt_d = is_event;
      cnt_d = is_event ? period : cnt_q - 1'b1;
      if (is_event) begin
        lvl_d  = ~lvl_q;
        step_d = 1'b1;
      end
      case (mode)
        M_IMPULSE: x_d = is_event ? amplitude : '0;
        // The first event itself already emits the step level.
        M_STEP:    x_d = (is_event || step_q) ? amplitude : '0;
        // Uses the post-toggle level so the event sample reflects the new half-period.
        M_SQUARE:  x_d = lvl_d ? amplitude : '0;
        default:   x_d = is_event ? '0 : x_q + amplitude;
      endcase
    end
  end

  // Capture FSM next state and buffer write strobe.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    buf_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // An event coinciding with the arm does not start capture.
        if (cap_arm) state_d = S_ARMED;
      end
      S_ARMED: begin
        // core_done in the entry cycle is deliberately not captured.
        if (is_event) begin
          state_d = S_CAPTURE;
          wptr_d  = '0;
        end
      end
      S_CAPTURE: begin
        if (core.core_done) begin
          buf_we = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if (&wptr_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (cap_arm) state_d = S_ARMED;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and stimulus registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      start_q <= 1'b0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      step_q  <= 1'b0;
      x_q     <= '0;
      evt_q   <= 1'b0;
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      start_q <= start_d;
      cnt_q   <= cnt_d;
      lvl_q   <= lvl_d;
      step_q  <= step_d;
      x_q     <= x_d;
      evt_q   <= evt_d;
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rdata_q <= mem[cap_raddr];
    end
  end

  // Capture buffer storage; contents intentionally survive reset.
  always_ff @(posedge ap_clk) begin
    if (buf_we) mem[wptr_q] <= core.core_return;
  end

  assign core.core_start = start_q;
  assign core.core_x     = x_q;
  assign stim_event      = evt_q;
  assign cap_busy        = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign cap_full        = (state_q == S_DONE);
  assign cap_rdata       = rdata_q;

endmodule

// File: tb/tb_iir_stim_seq.sv
// Directed bench for iir_stim_seq: stimulus waveforms, ready stalls,
// enable drop, capture sequencing and readback.
module tb_iir_stim_seq;
  localparam int W  = 20;
  localparam int PW = 10;
  localparam int CD = 64;
  localparam int AW = 6;

  logic          ap_clk;
  logic          ap_rst;
  logic          enable;
  logic [1:0]    mode;
  logic [W-1:0]  amplitude;
  logic [PW-1:0] period;
  logic          stim_event;
  logic          cap_arm;
  logic          cap_busy;
  logic          cap_full;
  logic [AW-1:0] cap_raddr;
  logic [W-1:0]  cap_rdata;

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  iir_stim_seq_if #(.W(W)) cif ();

  iir_stim_seq #(.W(W), .PERIOD_W(PW), .CAP_DEPTH(CD)) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .enable     (enable),
    .mode       (mode),
    .amplitude  (amplitude),
    .period     (period),
    .core       (cif),
    .stim_event (stim_event),
    .cap_arm    (cap_arm),
    .cap_busy   (cap_busy),
    .cap_full   (cap_full),
    .cap_raddr  (cap_raddr),
    .cap_rdata  (cap_rdata)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s cyc %0d: got 0x%0h want 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one cycle; core_return carries the cycle index it is driven in.
  task automatic tick();
    @(posedge ap_clk);
    #1;
    cyc++;
    cif.core_return = W'(cyc);
  endtask

  task automatic do_reset();
    ap_rst = 1'b1; enable = 1'b0; cap_arm = 1'b0; cap_raddr = '0;
    mode = 2'd0; amplitude = '0; period = '0;
    cif.core_ready = 1'b0; cif.core_done = 1'b0;
    tick(); tick();
    ap_rst = 1'b0;
    cyc = 0;
    cif.core_return = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_start"}, 32'(cif.core_start), 32'd0);
    chk({tag, "_x"},     32'(cif.core_x),     32'd0);
    chk({tag, "_evt"},   32'(stim_event),     32'd0);
    chk({tag, "_busy"},  32'(cap_busy),       32'd0);
    chk({tag, "_full"},  32'(cap_full),       32'd0);
    chk({tag, "_rdata"}, 32'(cap_rdata),      32'd0);
  endtask

  initial begin
    logic hit;
    logic [W-1:0] e;

    // Reset state and impulse with ready held high
    do_reset();
    chk_reset_outputs("rst");
    enable = 1'b1; period = 10'd3; mode = 2'd0; amplitude = 20'h10000; cif.core_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      hit = (c == 2 || c == 6 || c == 10);
      chk("imp_start", 32'(cif.core_start), 32'd1);
      chk("imp_x", 32'(cif.core_x), hit ? 32'h10000 : 32'd0);
      chk("imp_evt", 32'(stim_event), 32'(hit));
    end

    // Ready toggling: accepts on odd edges, impulse every 4th accept
    do_reset();
    enable = 1'b1; period = 10'd3; mode = 2'd0; amplitude = 20'h10000; cif.core_ready = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      hit = (c == 2 || c == 3 || c == 10 || c == 11 || c == 18 || c == 19);
      chk("stall_x", 32'(cif.core_x), hit ? 32'h10000 : 32'd0);
      chk("stall_evt", 32'(stim_event), 32'(c == 2 || c == 10 || c == 18));
      cif.core_ready = (c % 2) == 1;
    end

    // Square, period 1: pairs of 5 and 0
    do_reset();
    enable = 1'b1; period = 10'd1; mode = 2'd2; amplitude = 20'd5; cif.core_ready = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk("sq_x", 32'(cif.core_x), (c >= 2 && ((c - 2) / 2) % 2 == 0) ? 32'd5 : 32'd0);
    end

    // Step: 5 from the first event on
    do_reset();
    enable = 1'b1; period = 10'd1; mode = 2'd1; amplitude = 20'd5; cif.core_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("step_x", 32'(cif.core_x), (c >= 2) ? 32'd5 : 32'd0);
    end

    // Ramp with full-scale increment wraps downward
    do_reset();
    enable = 1'b1; period = 10'd3; mode = 2'd3; amplitude = 20'hFFFFF; cif.core_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      e = (c < 2) ? 20'd0 : 20'd0 - 20'((c - 2) % 4);
      chk("ramp_x", 32'(cif.core_x), 32'(e));
    end

    // Enable low during cycles 3..7: no skip, no duplicate impulse
    do_reset();
    enable = 1'b1; period = 10'd3; mode = 2'd0; amplitude = 20'h10000; cif.core_ready = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      hit = (c == 2 || c == 11 || c == 15);
      chk("en_start", 32'(cif.core_start), (c >= 4 && c <= 8) ? 32'd0 : 32'd1);
      chk("en_x", 32'(cif.core_x), hit ? 32'h10000 : 32'd0);
      chk("en_evt", 32'(stim_event), 32'(hit));
      enable = !(c >= 3 && c <= 7);
    end

    // Capture: arm at edge 3, event at edge 5 (n=5), arm during capture ignored
    do_reset();
    enable = 1'b1; period = 10'd3; mode = 2'd0; amplitude = 20'h10000;
    cif.core_ready = 1'b1; cif.core_done = 1'b1;
    for (int c = 1; c <= 72; c++) begin
      tick();
      if (c == 3)  chk("cap_busy_pre", 32'(cap_busy), 32'd0);
      if (c == 4)  chk("cap_busy_arm", 32'(cap_busy), 32'd1);
      if (c == 21) chk("cap_busy_rearm", 32'(cap_busy), 32'd1);
      if (c == 69) begin
        chk("cap_busy_69", 32'(cap_busy), 32'd1);
        chk("cap_full_69", 32'(cap_full), 32'd0);
      end
      if (c == 70) begin
        chk("cap_busy_70", 32'(cap_busy), 32'd0);
        chk("cap_full_70", 32'(cap_full), 32'd1);
      end
      cap_arm = (c == 3 || c == 20);
    end
    cif.core_done = 1'b0;
    for (int i = 0; i < CD; i++) begin
      cap_raddr = AW'(i);
      tick();
      chk("cap_rd", 32'(cap_rdata), 32'(6 + i));
    end
    chk("cap_full_hold", 32'(cap_full), 32'd1);

    // Arm coincident with event in IDLE: capture starts at following event (edge 9)
    do_reset();
    enable = 1'b1; period = 10'd3; mode = 2'd0; amplitude = 20'h10000;
    cif.core_ready = 1'b1; cif.core_done = 1'b1;
    for (int c = 1; c <= 74; c++) begin
      tick();
      if (c == 5)  chk("coin_evt", 32'(stim_event), 32'd0);
      if (c == 6) begin
        chk("coin_evt6", 32'(stim_event), 32'd1);
        chk("coin_busy", 32'(cap_busy), 32'd1);
      end
      if (c == 73) chk("coin_full_73", 32'(cap_full), 32'd0);
      if (c == 74) chk("coin_full_74", 32'(cap_full), 32'd1);
      cap_arm = (c == 5);
    end
    cap_raddr = 6'd0;
    tick();
    chk("coin_rd0", 32'(cap_rdata), 32'd10);
    cap_raddr = 6'd63;
    tick();
    chk("coin_rd63", 32'(cap_rdata), 32'd73);

    // Reset mid-capture then re-arm
    do_reset();
    enable = 1'b1; period = 10'd3; mode = 2'd0; amplitude = 20'h10000;
    cif.core_ready = 1'b1; cif.core_done = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (c == 10) chk("mid_busy", 32'(cap_busy), 32'd1);
      cap_arm = (c == 2);
    end
    ap_rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    ap_rst = 1'b0; cap_arm = 1'b1;
    tick();
    cap_arm = 1'b0;
    chk("rearm_busy", 32'(cap_busy), 32'd1);
    chk("rearm_start", 32'(cif.core_start), 32'd1);
    for (int c = 33; c <= 97; c++) begin
      tick();
      if (c == 33) chk("rearm_evt", 32'(stim_event), 32'd1);
      if (c == 96) chk("rearm_full_96", 32'(cap_full), 32'd0);
      if (c == 97) chk("rearm_full_97", 32'(cap_full), 32'd1);
    end
    cap_raddr = 6'd0;
    tick();
    chk("rearm_rd0", 32'(cap_rdata), 32'd33);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/iir_stim_seq.md
# iir_stim_seq

Parametrised stimulus sequencer and response capture for an `ap_ctrl_hs` IIR filter core. It drives the core's `x` input with impulse, step, square or ramp waveforms at a programmable period, paced by the `ap_start`/`ap_ready` handshake. After an arm request it records the core's `ap_return` samples into an on-chip buffer that can be read back. It sits in the FPGA top between the clock source and `iir_filter_core`, and is the bench/ILA front end for filter bring-up.

## Interface
- `W`, 20: sample width of `core_x` and `core_return`.
- `PERIOD_W`, 10: width of the period register and sample counter.
- `CAP_DEPTH`, 64: capture buffer depth; must be a power of 2.
- `ap_clk`  in  1  single clock; all logic is on its rising edge.
- `ap_rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  run request; gates `core_start`.
- `mode`  in  2  0 impulse, 1 step, 2 square, 3 ramp.
- `amplitude`  in  W  stimulus level (ramp: the per-sample increment).
- `period`  in  PERIOD_W  event spacing; events occur every period+1 accepted samples.
- `core_start`  out  1  to core `ap_start`.
- `core_ready`  in  1  from core `ap_ready`.
- `core_done`  in  1  from core `ap_done`.
- `core_return`  in  W  from core `ap_return`.
- `core_x`  out  W  to core `x`.
- `stim_event`  out  1  one-cycle pulse on each event accept.
- `cap_arm`  in  1  single-cycle capture request.
- `cap_busy`  out  1  high in ARMED or CAPTURE.
- `cap_full`  out  1  high in DONE.
- `cap_raddr`  in  log2(CAP_DEPTH)  buffer read address.
- `cap_rdata`  out  W  buffer read data.

## Operation
- **Reset values:** `core_start`=0, `core_x`=0, `stim_event`=0, `cap_busy`=0, `cap_full`=0, `cap_rdata`=0. Internal state: sample counter `cnt`=0, square level=0, step latch=0, capture FSM=IDLE, write pointer=0.
- **Start:** `core_start` is registered as `enable`, so it follows `enable` one cycle later.
- **Accept:** `core_start && core_ready`. No state changes without an accept, except the capture FSM.
- **Event:** an accept with `cnt==0`. On an event, `cnt <= period` and `stim_event` pulses the next cycle. On any other accept, `cnt <= cnt-1`.
- **Stimulus:** `core_x` is registered and updated on each accept. `mode` and `amplitude` are sampled on that accept.
  - Impulse: `amplitude` if the accept is an event, else 0.
  - Step: 0 until the first event after reset, then `amplitude`.
  - Square: the level toggles on each event; `core_x` = level ? `amplitude` : 0.
  - Ramp: 0 on an event, else `core_x + amplitude` modulo 2^W (wraps, no saturation).
- **Capture FSM:**
  - IDLE: `cap_arm` moves to ARMED.
  - ARMED: an event moves to CAPTURE and clears the write pointer.
  - CAPTURE: each `core_done` writes `core_return` to buf[wptr] and increments wptr. The write that makes CAP_DEPTH entries moves to DONE.
  - DONE: `cap_arm` moves to ARMED and clears `cap_full`.
  - `cap_arm` in ARMED or CAPTURE is ignored.
- **Simultaneous events:**
  - `core_done` in the same cycle as the event that enters CAPTURE is not captured.
  - `cap_arm` and an event in the same cycle in IDLE: enter ARMED only; wait for the next event.
- **Readback:** `cap_rdata <= buf[cap_raddr]` every cycle, regardless of state. Buffer contents are not reset.
- **Dropping `enable`:** `core_start` falls the next cycle; `cnt`, the level registers and the FSM hold.
- **`ap_rst` mid-capture:** FSM returns to IDLE and `cap_full`=0. Buffer holds stale data.

## Timing
- Stimulus latency: the value selected on accept k appears on `core_x` the next cycle and is consumed by accept k+1.
- With `core_ready` held high, `core_x` changes every cycle; impulses are spaced period+1 cycles apart.
- `stim_event` is high exactly one cycle after the event accept.
- `cap_busy` / `cap_full` reflect the FSM register; they change the cycle after the triggering input.
- Read latency: 1 cycle from `cap_raddr` to `cap_rdata`.
- Minimum capture time is CAP_DEPTH `core_done` pulses.

## Test plan
- **Impulse:** reset, then `enable`=1, `period`=3, `mode`=0, `amplitude`=0x10000, `core_ready`=1. Required: `core_start` rises at cycle 1; `core_x`=0x10000 at cycles 2, 6, 10, and 0 otherwise; `stim_event` high at 2, 6, 10.
- **Ready stalls:** same setup, `core_ready` toggling 1,0,1,0. Required: `core_x` and `cnt` change only after accepts; impulse every 4th accept.
- **Square / step / ramp:**
  - `mode`=2, `period`=1, `amplitude`=5: `core_x` shows pairs of 5 and 0, toggling every 2 accepts.
  - `mode`=1: `core_x` holds 5 after the first event.
  - `mode`=3, `amplitude`=0xFFFFF, W=20: sequence 0, 0xFFFFF, 0xFFFFE, wrapping modulo 2^20.
- **Capture:** `CAP_DEPTH`=64, `cap_arm` pulse, `core_done`=1 with `core_return` counting 0..; the counter value present in the event cycle (not captured) is n. Required:
  - `cap_busy` high from the next cycle.
  - After the next event, 64 writes, then `cap_full`=1 and `cap_busy`=0.
  - Readback at addr i returns n+1+i one cycle after the address is applied.
- **Boundaries:**
  - `cap_arm` during CAPTURE: no effect.
  - `cap_arm` coincident with an event in IDLE: capture starts at the following event.
  - `ap_rst` mid-capture: all outputs return to reset values next cycle; re-arm works.
- **Enable drop:** `enable`=0 for 5 cycles mid-period. Required: `core_start`=0 from the next cycle; the impulse position resumes in sequence without skip or duplicate.
